multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives every datapath enable and mux select, and produces the 2-bit `aluOp` consumed by the ALU control decoder. Stalls on a memory ready handshake and flags unsupported opcodes.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rstN`  in  1  synchronous active-low reset
- `opCode`  in  6  instruction[31:26] from the instruction register
- `memReady`  in  1  memory completes the current read/write this cycle
- `pcWrite`, `pcWriteCond`, `iorD`, `memRead`, `memWrite`, `memToReg`, `irWrite`, `regWrite`, `regDst`, `aluSrcA`  out  1 each  datapath controls
- `aluSrcB`  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
- `pcSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `aluOp`  out  2  00 add, 01 subtract, 10 decode func, 11 add (immediate)
- `instrDone`  out  1  one-cycle pulse in the last state of each instruction
- `illegalOp`  out  1  sticky flag: unsupported opcode decoded
- `state`  out  4  current state, for debug

## Operation
- Supported opcodes:
  - 000000 R-type
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 000010 j
  - 001000 addi
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- Moore outputs decoded from `state`. Any output not listed for a state is 0.
- FETCH:
  - Outputs: `memRead`=1, `iorD`=0, `aluSrcA`=0, `aluSrcB`=01, `aluOp`=00, `pcSource`=00.
  - `irWrite`=`pcWrite`=`memReady`.
  - Stays in FETCH while `memReady`=0; goes to DECODE when `memReady`=1.
- DECODE:
  - Outputs: `aluSrcA`=0, `aluSrcB`=11, `aluOp`=00.
  - Next state: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX, any other opcode→FETCH.
  - Any other opcode also sets `illegalOp`.
- MEMADR: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `memRead`=1, `iorD`=1. Waits for `memReady`, then goes to MEMWB.
- MEMWB: `regDst`=0, `memToReg`=1, `regWrite`=1, `instrDone`=1. Goes to FETCH.
- MEMWR: `memWrite`=1, `iorD`=1. Waits for `memReady`. `instrDone`=`memReady`. Goes to FETCH.
- EXEC: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10. Goes to ALUWB.
- ALUWB: `regDst`=1, `memToReg`=0, `regWrite`=1, `instrDone`=1. Goes to FETCH.
- BRANCH: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=01, `pcWriteCond`=1, `pcSource`=01, `instrDone`=1. Goes to FETCH.
- JUMP: `pcWrite`=1, `pcSource`=10, `instrDone`=1. Goes to FETCH.
- ADDIEX: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=11. Goes to ADDIWB.
- ADDIWB: `regDst`=0, `memToReg`=0, `regWrite`=1, `instrDone`=1. Goes to FETCH.
- `illegalOp` clears only on reset. The FSM keeps running after it is set.

## Timing
- While `rstN`=0, the following are forced to 0 combinationally: `pcWrite`, `pcWriteCond`, `memRead`, `memWrite`, `irWrite`, `regWrite`, `instrDone`.
- At the first edge with `rstN`=0: `state`=FETCH (0) and `illegalOp`=0.
- Reset taken in any state, including mid memory wait, abandons the instruction with no further writes.
- The cycle after `rstN` rises is FETCH with `memRead`=1.
- Latency with `memReady` held at 1:
  - beq, j: 3 cycles
  - R-type, sw, addi: 4 cycles
  - lw: 5 cycles
  - illegal opcode: 2 cycles (FETCH, DECODE)
- Each `memReady`=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- During a wait, `iorD`, `memRead` and `memWrite` stay constant.
- `memReady` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `opCode` is sampled only in DECODE and MEMADR. The instruction register is stable there because `irWrite`=0.
- `instrDone` and the final write-enable assert in the same cycle. The next edge enters FETCH.

## Test plan
- Reset then R-type:
  - Stimulus: `rstN`=0 for 2 cycles while in EXEC, then release; `opCode`=000000, `memReady`=1.
  - Required: state sequence 0,1,6,7,0; `aluOp`=10 in EXEC; `regWrite`=`regDst`=1 in ALUWB; `instrDone` high exactly 1 cycle.
- lw with 2 wait cycles in MEMRD:
  - Required: sequence 0,1,2,3,3,3,4,0.
  - `memRead`=`iorD`=1 throughout MEMRD; `memToReg`=`regWrite`=1 in MEMWB.
- sw then beq:
  - sw required: MEMWR asserts `memWrite` once `memReady`=1; `regWrite` never asserted.
  - beq required: BRANCH shows `aluOp`=01, `pcWriteCond`=1, `pcSource`=01.
- j and addi:
  - j required: JUMP `pcWrite`=1, `pcSource`=10, 3-cycle latency.
  - addi required: ADDIEX `aluOp`=11, `aluSrcB`=10; ADDIWB `regWrite`=1, `regDst`=0.
- Illegal opcode 111111:
  - Required: DECODE→FETCH; `illegalOp` rises the cycle after DECODE and stays high across a following valid instruction.
  - `illegalOp` clears only after a `rstN`=0 edge.
- Fetch stall plus mid-wait reset:
  - Stimulus: `memReady`=0 for 3 cycles, then `rstN` pulsed low during MEMWR.
  - Required: `pcWrite`=`irWrite`=0 during the stall; `memWrite` drops in the reset cycle; `state`=0 after the edge.

Source files
------------

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multi-cycle MIPS datapath: sequences instructions
//   and decodes every datapath enable / mux select from the current state.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control (
    input  logic       clk,
    input  logic       rstN,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       memToReg,
    output logic       irWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic [1:0] aluOp,
    output logic       instrDone,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    // Write enables before reset gating
    logic w_pcWrite, w_pcWriteCond, w_memRead, w_memWrite;
    logic w_irWrite, w_regWrite, w_instrDone;

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opCode)
                    c_OP_LW, c_OP_SW: state_d = S_MEMADR;
                    c_OP_RTYPE:       state_d = S_EXEC;
                    c_OP_BEQ:         state_d = S_BRANCH;
                    c_OP_J:           state_d = S_JUMP;
                    c_OP_ADDI:        state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opCode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_irWrite     = 1'b0;
        w_regWrite    = 1'b0;
        w_instrDone   = 1'b0;
        iorD          = 1'b0;
        memToReg      = 1'b0;
        regDst        = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        pcSource      = 2'b00;
        aluOp         = 2'b00;
        case (state_q)
            S_FETCH: begin
                w_memRead = 1'b1;
                aluSrcB   = 2'b01;
                w_irWrite = memReady;
                w_pcWrite = memReady;
            end
            S_DECODE: aluSrcB = 2'b11;
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                w_memRead = 1'b1;
                iorD      = 1'b1;
            end
            S_MEMWB: begin
                memToReg    = 1'b1;
                w_regWrite  = 1'b1;
                w_instrDone = 1'b1;
            end
            S_MEMWR: begin
                w_memWrite  = 1'b1;
                iorD        = 1'b1;
                w_instrDone = memReady;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_ALUWB: begin
                regDst      = 1'b1;
                w_regWrite  = 1'b1;
                w_instrDone = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA       = 1'b1;
                aluOp         = 2'b01;
                w_pcWriteCond = 1'b1;
                pcSource      = 2'b01;
                w_instrDone   = 1'b1;
            end
            S_JUMP: begin
                w_pcWrite   = 1'b1;
                pcSource    = 2'b10;
                w_instrDone = 1'b1;
            end
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = 2'b11;
            end
            S_ADDIWB: begin
                w_regWrite  = 1'b1;
                w_instrDone = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset suppresses all side effects immediately, even mid memory wait
    assign pcWrite     = w_pcWrite     & rstN;
    assign pcWriteCond = w_pcWriteCond & rstN;
    assign memRead     = w_memRead     & rstN;
    assign memWrite    = w_memWrite    & rstN;
    assign irWrite     = w_irWrite     & rstN;
    assign regWrite    = w_regWrite    & rstN;
    assign instrDone   = w_instrDone   & rstN;
    assign illegalOp   = illegal_q;
    assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// tb_multicycle_control
//   Directed scoreboard bench for multicycle_control.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

    localparam logic [5:0] c_R    = 6'b000000;
    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_J    = 6'b000010;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rstN;
    logic [5:0] opCode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg;
    logic       irWrite, regWrite, regDst, aluSrcA, instrDone, illegalOp;
    logic [1:0] aluSrcB, pcSource, aluOp;
    logic [3:0] state;

    multicycle_control dut (
        .clk        (clk),
        .rstN       (rstN),
        .opCode     (opCode),
        .memReady   (memReady),
        .pcWrite    (pcWrite),
        .pcWriteCond(pcWriteCond),
        .iorD       (iorD),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memToReg   (memToReg),
        .irWrite    (irWrite),
        .regWrite   (regWrite),
        .regDst     (regDst),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .pcSource   (pcSource),
        .aluOp      (aluOp),
        .instrDone  (instrDone),
        .illegalOp  (illegalOp),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;
    logic exp_ill  = 1'b0;

    // Packing order: pcWrite pcWriteCond iorD memRead memWrite memToReg irWrite
    // regWrite regDst aluSrcA aluSrcB[2] pcSource[2] aluOp[2] instrDone
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic rn);
        logic pw, pwc, iod, mrd, mwr, m2r, irw, rw, rd, asa, done;
        logic [1:0] asb, psrc, aop;
        {pw, pwc, iod, mrd, mwr, m2r, irw, rw, rd, asa, done} = '0;
        asb = 2'b00; psrc = 2'b00; aop = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iod = 1; end
            4'd4:  begin m2r = 1; rw = 1; done = 1; end
            4'd5:  begin mwr = 1; iod = 1; done = mr; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; done = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
            4'd9:  begin pw = 1; psrc = 2'b10; done = 1; end
            4'd10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            4'd11: begin rw = 1; done = 1; end
            default: ;
        endcase
        if (!rn) {pw, pwc, mrd, mwr, irw, rw, done} = '0;
        return {pw, pwc, iod, mrd, mwr, m2r, irw, rw, rd, asa, asb, psrc, aop, done};
    endfunction

    // One cycle of stimulus: drive inputs and queue the response expected this cycle
    task automatic cyc(input logic rn, input logic [5:0] op, input logic mr, input logic [3:0] st);
        exp_t e;
        rstN = rn; opCode = op; memReady = mr;
        e.st = st; e.ctrl = exp_ctrl(st, mr, rn); e.ill = exp_ill;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [16:0] got;
            e = exp_q.pop_front();
            cyc_no++;
            got = {pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
                   regWrite, regDst, aluSrcA, aluSrcB, pcSource, aluOp, instrDone};
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL state cyc%0d: got %0d expected %0d", cyc_no, state, e.st);
            end
            n_checks++;
            if (got !== e.ctrl) begin
                n_fail++;
                $display("FAIL ctrl cyc%0d state %0d: got %b expected %b", cyc_no, e.st, got, e.ctrl);
            end
            n_checks++;
            if (illegalOp !== e.ill) begin
                n_fail++;
                $display("FAIL illegalOp cyc%0d: got %b expected %b", cyc_no, illegalOp, e.ill);
            end
        end
    end

    initial begin
        rstN = 1'b0; opCode = c_R; memReady = 1'b1;
        @(posedge clk); #1;

        // Reach EXEC, reset there for two cycles, then a full R-type
        cyc(1, c_R, 1, 0); cyc(1, c_R, 1, 1);
        cyc(0, c_R, 1, 6); cyc(0, c_R, 1, 0);
        cyc(1, c_R, 1, 0); cyc(1, c_R, 1, 1); cyc(1, c_R, 1, 6); cyc(1, c_R, 1, 7);

        // lw with two wait cycles in MEMRD
        cyc(1, c_LW, 1, 0); cyc(1, c_LW, 1, 1); cyc(1, c_LW, 1, 2);
        cyc(1, c_LW, 0, 3); cyc(1, c_LW, 0, 3); cyc(1, c_LW, 1, 3); cyc(1, c_LW, 1, 4);

        // sw with one MEMWR wait, then beq
        cyc(1, c_SW, 1, 0); cyc(1, c_SW, 1, 1); cyc(1, c_SW, 1, 2);
        cyc(1, c_SW, 0, 5); cyc(1, c_SW, 1, 5);
        cyc(1, c_BEQ, 1, 0); cyc(1, c_BEQ, 1, 1); cyc(1, c_BEQ, 1, 8);

        // j, addi
        cyc(1, c_J, 1, 0); cyc(1, c_J, 1, 1); cyc(1, c_J, 1, 9);
        cyc(1, c_ADDI, 1, 0); cyc(1, c_ADDI, 1, 1); cyc(1, c_ADDI, 1, 10); cyc(1, c_ADDI, 1, 11);

        // memReady is ignored outside FETCH/MEMRD/MEMWR
        cyc(1, c_BEQ, 1, 0); cyc(1, c_BEQ, 0, 1); cyc(1, c_BEQ, 0, 8);

        // Illegal opcode: sticky across a valid instruction until reset
        cyc(1, c_BAD, 1, 0); cyc(1, c_BAD, 1, 1);
        exp_ill = 1'b1;
        cyc(1, c_R, 1, 0); cyc(1, c_R, 1, 1); cyc(1, c_R, 1, 6); cyc(1, c_R, 1, 7);
        cyc(0, c_R, 1, 0);
        exp_ill = 1'b0;

        // Fetch stall, then reset in the middle of a MEMWR wait
        cyc(1, c_SW, 0, 0); cyc(1, c_SW, 0, 0); cyc(1, c_SW, 0, 0);
        cyc(1, c_SW, 1, 0); cyc(1, c_SW, 1, 1); cyc(1, c_SW, 1, 2);
        cyc(1, c_SW, 0, 5); cyc(0, c_SW, 0, 5);
        cyc(1, c_SW, 1, 0); cyc(1, c_SW, 1, 1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
